// File: rtl/systolic_driver_if.sv
// Handshake and operand/result bundle between the systolic driver,
// its matrix producer/consumer and the array.
interface systolic_driver_if #(
  parameter int W = 16,
  parameter int N = 3
);
  logic             i_start;
  logic             i_mode;
  logic [W*N*N-1:0] i_A_mat;
  logic [W*N*N-1:0] i_B_mat;
  logic             o_en;
  logic             o_sync;
  logic             o_mode;
  logic [W*N-1:0]   o_A;
  logic [W*N-1:0]   o_B;
  logic [W*N*N-1:0] i_C;
  logic [W*N*N-1:0] o_C;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;
  logic [15:0]      o_cycles;

  modport master (
    output i_start, i_mode, i_A_mat, i_B_mat,
    output i_C, i_ready,
    input  o_en, o_sync, o_mode, o_A, o_B,
    input  o_C, o_valid, o_busy, o_cycles
  );

  modport slave (
    input  i_start, i_mode, i_A_mat, i_B_mat,
    input  i_C, i_ready,
    output o_en, o_sync, o_mode, o_A, o_B,
    output o_C, o_valid, o_busy, o_cycles
  );
endinterface

// File: rtl/systolic_driver.sv
// Skewed operand feeder and result capture for an NxN systolic array.
// Define SYSTOLIC_DRIVER_PERF_EN to enable the o_cycles latency counter.
module systolic_driver #(
  parameter int W = 16,
  parameter int N = 3,
  parameter int DRAIN = N + 1
) (
  input logic              i_clk,
  input logic              i_rst,
  systolic_driver_if.slave bus
);
  localparam int FEED_LEN = 3*N - 2;
  localparam int SMAX = (FEED_LEN > DRAIN) ? FEED_LEN : DRAIN;
  localparam int SW = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int MW = W*N*N;
  localparam int LW = W*N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_FEED,
    S_DRN,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   step, step_n;
  logic [MW-1:0]   a_lat, b_lat;
  logic            mode_lat;
  logic            load, cap, run_n, mode_n;
  logic [LW-1:0]   a_n, b_n;

  logic            en, sync, mode, valid, busy;
  logic [LW-1:0]   a_out, b_out;
  logic [MW-1:0]   c_out;

  always_comb begin
    state_n = state;
    step_n  = step;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          load    = 1'b1;
          state_n = S_SYNC;
        end
      end
      S_SYNC: begin
        state_n = S_FEED;
        step_n  = '0;
      end
      S_FEED: begin
        if (step == SW'(FEED_LEN - 1)) begin
          state_n = S_DRN;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_DRN: begin
        if (step == SW'(DRAIN - 1)) begin
          state_n = S_DONE;
          cap     = 1'b1;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          if (bus.i_start) begin
            load    = 1'b1;
            state_n = S_SYNC;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Lane values are computed for the coming cycle so the ports stay registered.
  always_comb begin
    a_n = '0;
    b_n = '0;
    if (state_n == S_FEED) begin
      for (int l = 0; l < N; l++) begin
        if (int'(step_n) >= l && int'(step_n) - l < N) begin
          a_n[l*W +: W] = a_lat[(l*N + int'(step_n) - l)*W +: W];
          b_n[l*W +: W] = b_lat[((int'(step_n) - l)*N + l)*W +: W];
        end
      end
    end
  end

  assign run_n  = (state_n == S_SYNC) || (state_n == S_FEED) ||
                  (state_n == S_DRN);
  assign mode_n = load ? bus.i_mode : mode_lat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      step     <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      mode_lat <= 1'b0;
      en       <= 1'b0;
      sync     <= 1'b0;
      mode     <= 1'b0;
      a_out    <= '0;
      b_out    <= '0;
      c_out    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (load) begin
        a_lat    <= bus.i_A_mat;
        b_lat    <= bus.i_B_mat;
        mode_lat <= bus.i_mode;
      end
      en    <= run_n;
      sync  <= (state_n == S_SYNC);
      mode  <= run_n ? mode_n : 1'b0;
      a_out <= a_n;
      b_out <= b_n;
      busy  <= (state_n != S_IDLE);
      if (cap) begin
        c_out <= bus.i_C;
        valid <= 1'b1;
      end else if (valid && bus.i_ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.o_en    = en;
  assign bus.o_sync  = sync;
  assign bus.o_mode  = mode;
  assign bus.o_A     = a_out;
  assign bus.o_B     = b_out;
  assign bus.o_C     = c_out;
  assign bus.o_valid = valid;
  assign bus.o_busy  = busy;

`ifdef SYSTOLIC_DRIVER_PERF_EN
  logic [15:0] cycles;

  // Loaded with 1 so the count equals the cycle index since acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycles <= '0;
    end else if (load) begin
      cycles <= 16'd1;
    end else if ((state == S_SYNC || state == S_FEED ||
                  state == S_DRN) && cycles != 16'hFFFF) begin
      cycles <= cycles + 16'd1;
    end
  end

  assign bus.o_cycles = cycles;
`else
  assign bus.o_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_driver.sv
// Scoreboard bench for systolic_driver with a behavioural
// output-stationary array model producing i_C.
module tb_systolic_driver;
  localparam int W = 16;
  localparam int N = 3;
  localparam int MW = W*N*N;
`ifdef SYSTOLIC_DRIVER_PERF_EN
  localparam int CYC_AT_VALID = 13;
`else
  localparam int CYC_AT_VALID = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_driver_if #(.W(W), .N(N)) bus ();

  systolic_driver #(.W(W), .N(N), .DRAIN(N + 1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int hs = 0;
  int exp_hs = 0;
  logic [MW-1:0] expq[$];

  // Output-stationary array: A flows right, B flows down.
  int acc[N][N];
  logic [W-1:0] ah[N][N];
  logic [W-1:0] bv[N][N];

  always @(posedge clk) begin
    if (bus.o_en) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          logic [W-1:0] ai, bi;
          if (c == 0) ai = bus.o_A[r*W +: W];
          else ai = ah[r][c-1];
          if (r == 0) bi = bus.o_B[c*W +: W];
          else bi = bv[r-1][c];
          ah[r][c] <= ai;
          bv[r][c] <= bi;
          if (bus.o_sync) acc[r][c] <= 0;
          else acc[r][c] <= acc[r][c] + int'(ai) * int'(bi);
        end
      end
    end
  end

  always_comb begin
    bus.i_C = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bus.i_C[(r*N+c)*W +: W] = acc[r][c][W-1:0];
  end

  function automatic logic [MW-1:0] m9(input int a0, a1, a2, a3, a4,
                                       a5, a6, a7, a8);
    logic [MW-1:0] v;
    v = '0;
    v[0*W +: W] = W'(a0); v[1*W +: W] = W'(a1); v[2*W +: W] = W'(a2);
    v[3*W +: W] = W'(a3); v[4*W +: W] = W'(a4); v[5*W +: W] = W'(a5);
    v[6*W +: W] = W'(a6); v[7*W +: W] = W'(a7); v[8*W +: W] = W'(a8);
    return v;
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] got,
                     input logic [MW-1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic chki(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      hs++;
      if (expq.size() == 0) begin
        chki("unexpected_result", 1, 0);
      end else begin
        chk("o_C", bus.o_C, expq.pop_front());
        chki("o_cycles_at_valid", int'(bus.o_cycles), CYC_AT_VALID);
      end
    end
  end

  task automatic check_idle(input string tag);
    int bad;
    bad = 0;
    if (bus.o_en !== 1'b0) bad |= 1;
    if (bus.o_sync !== 1'b0) bad |= 2;
    if (bus.o_mode !== 1'b0) bad |= 4;
    if (bus.o_A !== '0) bad |= 8;
    if (bus.o_B !== '0) bad |= 16;
    if (bus.o_valid !== 1'b0) bad |= 32;
    if (bus.o_busy !== 1'b0) bad |= 64;
    if (bus.o_cycles !== '0) bad |= 128;
    chki({tag, "_ctrl_zero_mask"}, bad, 0);
    chk({tag, "_o_C"}, bus.o_C, '0);
  endtask

  task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input logic m);
    @(posedge clk);
    #1;
    bus.i_A_mat = a;
    bus.i_B_mat = b;
    bus.i_mode = m;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic watch(input int first, input bit skew, input int inj,
                       input logic m);
    int vcyc;
    bit syncbad, skewbad, busybad, modebad, cycbad;
    vcyc = 0;
    syncbad = 0; skewbad = 0; busybad = 0; modebad = 0; cycbad = 0;
    for (int k = first; k < 60; k++) begin
      @(negedge clk);
      if (bus.o_sync !== (k == 1)) syncbad = 1;
      if (bus.o_busy !== 1'b1) busybad = 1;
      if (!bus.o_valid && bus.o_mode !== m) modebad = 1;
      if (bus.o_valid && bus.o_mode !== 1'b0) modebad = 1;
`ifndef SYSTOLIC_DRIVER_PERF_EN
      if (bus.o_cycles !== '0) cycbad = 1;
`endif
      if (skew && k >= 2 && k <= 8) begin
        for (int l = 0; l < N; l++) begin
          bit on;
          on = (k - 2 >= l) && (k - 2 <= l + 2);
          if ((bus.o_A[l*W +: W] != '0) !== on) skewbad = 1;
          if ((bus.o_B[l*W +: W] != '0) !== on) skewbad = 1;
        end
      end
      if (inj != 0 && k == inj) bus.i_start = 1'b1;
      if (inj != 0 && k == inj + 1) bus.i_start = 1'b0;
      if (bus.o_valid) begin
        vcyc = k;
        break;
      end
    end
    chki("valid_cycle", vcyc, 13);
    chki("sync_pulse", int'(syncbad), 0);
    chki("busy_in_job", int'(busybad), 0);
    chki("mode_out", int'(modebad), 0);
    chki("cycles_zero", int'(cycbad), 0);
    if (skew) chki("skew_lanes", int'(skewbad), 0);
  endtask

  initial begin
    logic [MW-1:0] ident, ident2, seq, all5, all7;
    logic [MW-1:0] snap;
    bit stable, extra;
    ident  = m9(1, 0, 0, 0, 1, 0, 0, 0, 1);
    ident2 = m9(2, 0, 0, 0, 2, 0, 0, 0, 2);
    seq    = m9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    all5   = m9(5, 5, 5, 5, 5, 5, 5, 5, 5);
    all7   = m9(7, 7, 7, 7, 7, 7, 7, 7, 7);
    bus.i_start = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_A_mat = '0;
    bus.i_B_mat = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // identity x [1..9]
    expq.push_back(m9(1, 2, 3, 4, 5, 6, 7, 8, 9));
    exp_hs++;
    launch(ident, seq, 1'b1);
    watch(1, 1'b0, 0, 1'b1);
    @(negedge clk);
    chki("job1_valid_clear", int'(bus.o_valid), 0);
    chki("job1_busy_clear", int'(bus.o_busy), 0);

    // all 5 x all 7: every lane shape visible
    expq.push_back(m9(105, 105, 105, 105, 105, 105, 105, 105, 105));
    exp_hs++;
    launch(all5, all7, 1'b0);
    watch(1, 1'b1, 0, 1'b0);
    @(negedge clk);

    // backpressure: [1..9] squared
    bus.i_ready = 1'b0;
    expq.push_back(m9(30, 36, 42, 66, 81, 96, 102, 126, 150));
    exp_hs++;
    launch(seq, seq, 1'b1);
    watch(1, 1'b0, 0, 1'b1);
    snap = bus.o_C;
    stable = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b1 || bus.o_C !== snap) stable = 0;
    end
    chki("bp_stable", int'(stable), 1);
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chki("bp_valid_clear", int'(bus.o_valid), 0);

    // start during FEED step 2 is ignored
    expq.push_back(m9(1, 2, 3, 4, 5, 6, 7, 8, 9));
    exp_hs++;
    launch(seq, ident, 1'b0);
    watch(1, 1'b0, 4, 1'b0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) extra = 1;
    end
    chki("ignored_start", int'(extra), 0);

    // handshake and start in the same DONE cycle
    expq.push_back(m9(1, 2, 3, 4, 5, 6, 7, 8, 9));
    exp_hs++;
    launch(ident, seq, 1'b1);
    watch(1, 1'b0, 0, 1'b1);
    bus.i_A_mat = all5;
    bus.i_B_mat = all7;
    bus.i_start = 1'b1;
    expq.push_back(m9(105, 105, 105, 105, 105, 105, 105, 105, 105));
    exp_hs++;
    @(negedge clk);
    bus.i_start = 1'b0;
    chki("b2b_sync", int'(bus.o_sync), 1);
    chki("b2b_valid_clear", int'(bus.o_valid), 0);
    watch(2, 1'b0, 0, 1'b1);
    @(negedge clk);

    // reset during DRAIN aborts the job
    launch(seq, seq, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;

    expq.push_back(m9(2, 4, 6, 8, 10, 12, 14, 16, 18));
    exp_hs++;
    launch(ident2, seq, 1'b0);
    watch(1, 1'b0, 0, 1'b0);
    @(negedge clk);
    chki("job7_valid_clear", int'(bus.o_valid), 0);

    repeat (3) @(negedge clk);
    chki("handshakes", hs, exp_hs);
    chki("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/systolic_driver.md
# systolic_driver

Front-end controller for the N×N systolic matrix-multiply array. Accepts whole A and B operand matrices with a start pulse. Generates the diagonally skewed row/column streams plus the enable/sync/mode controls the array consumes. After a fixed drain interval it captures the array's flattened C output and presents it behind a valid/ready handshake. It sits between the matrix-level producer/consumer and the array: it is the initiator to the array's compute-responder.

## Interface
- W, 16: element width in bits; matches the array's W.
- N, 3: array dimension; matches the array's N.
- DRAIN, N+1: cycles after the final feed step before the array's C is captured.

- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a multiply; sampled only in IDLE, or in DONE on the handshake cycle.
- i_mode  in  1  mode latched at start acceptance; driven to the array for the whole job.
- i_A_mat  in  W*N*N  A[r][k] at bits (r*N+k)*W +: W; latched at start acceptance.
- i_B_mat  in  W*N*N  B[k][c] at bits (k*N+c)*W +: W; latched at start acceptance.
- o_en  out  1  array enable.
- o_sync  out  1  array accumulator-clear pulse.
- o_mode  out  1  array mode.
- o_A  out  W*N  row lane r at bits r*W +: W.
- o_B  out  W*N  column lane c at bits c*W +: W.
- i_C  in  W*N*N  array result, C[r][c] at (r*N+c)*W +: W.
- o_C  out  W*N*N  captured result, same layout as i_C.
- o_valid  out  1  o_C holds a complete result.
- i_ready  in  1  consumer accepts o_C.
- o_busy  out  1  high in every state except IDLE.
- o_cycles  out  16  job latency counter (see Configuration).

## Operation
- States: IDLE, SYNC, FEED, DRAIN, DONE. A step counter is sized for max(3N-2, DRAIN).
- IDLE, with i_start=1:
  - latch i_A_mat, i_B_mat, i_mode.
  - go to SYNC.
- SYNC (1 cycle):
  - o_en=1, o_sync=1, o_A=o_B=0.
  - go to FEED with step t=0.
- FEED (3N-2 cycles, t=0..3N-3):
  - o_en=1, o_sync=0.
  - lane r of o_A = A[r][t-r] if 0≤t-r<N, else 0.
  - lane c of o_B = B[t-c][c] if 0≤t-c<N, else 0.
  - after t=3N-3, go to DRAIN.
- DRAIN (DRAIN cycles):
  - o_en=1, o_A=o_B=0.
  - on the clock edge ending the last DRAIN cycle: o_C<=i_C and o_valid<=1; go to DONE.
- DONE:
  - o_en=0; o_valid and o_C held stable until o_valid&&i_ready.
  - on that edge: clear o_valid; if i_start=1 in the same cycle, latch new operands and go to SYNC (back-to-back), else go to IDLE.
- i_start in SYNC/FEED/DRAIN, or in DONE without i_ready, is ignored (no queuing).
- o_mode = latched mode during SYNC..DRAIN; 0 in IDLE/DONE.
- No arithmetic is performed here; element width W is passed through unchanged.

## Timing
- Reset: on any i_rst edge, state=IDLE; every output is 0 (o_en, o_sync, o_mode, o_A, o_B, o_C, o_valid, o_busy, o_cycles). Latched operands are cleared.
- Reset mid-job aborts the job with no result; the next start runs a full clean sequence.
- Start accepted at edge of cycle 0 → SYNC in cycle 1; FEED in cycles 2..3N-1; DRAIN in cycles 3N..3N+DRAIN-1.
- o_valid first high in cycle 3N+DRAIN. Defaults: cycle 13.
- o_valid never drops without i_ready. o_C never changes while o_valid=1.
- Back-to-back: handshake and start in the same cycle give o_sync in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SYSTOLIC_DRIVER_PERF_EN defined:
  - o_cycles counts from 0 at start acceptance and increments each cycle through SYNC..DRAIN.
  - it holds in DONE, so it equals 3N+DRAIN (13 at defaults) when o_valid rises.
  - it saturates at 16'hFFFF and clears on the next start acceptance.
- Undefined: o_cycles tied to 0; no counter logic.

## Test plan
- A=identity, B=[1..9] row-major, i_ready=1 → o_C=[1,2,3,4,5,6,7,8,9], o_valid rising in cycle 13.
- Skew check, A all 5, B all 7: o_A lane r is nonzero exactly in FEED steps r..r+2; o_B lane c likewise in steps c..c+2; o_sync high exactly in cycle 1.
- Backpressure: i_ready low 5 cycles after o_valid → o_valid and o_C stable throughout; accepted on the first i_ready=1 edge, o_valid=0 next cycle.
- i_start pulsed in FEED step 2 → ignored: exactly one o_valid, o_busy drops after the handshake. Handshake+start in DONE → o_sync high in the next cycle.
- i_rst asserted in DRAIN → next cycle all outputs 0 and state IDLE; a subsequent job with A=2·I, B=[1..9] gives o_C=[2,4,…,18].
- With SYSTOLIC_DRIVER_PERF_EN: o_cycles=13 at o_valid (N=3, DRAIN=4). Without it: o_cycles=0 in every cycle.
